// File: rtl/intake_loader.sv
// Serial decimal capacity entry: accumulates digits, range-checks on enter, issues a one-cycle
// give_valid to the prime finder, then waits for out_valid or a watchdog before accepting more.
module intake_loader #(
  parameter int unsigned MIN_INTAKE = 3,
  parameter int unsigned MAX_INTAKE = 9972,
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned WAIT_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        digit_enter,
  input  logic        out_valid,
  output logic        ready,
  output logic [13:0] Intake,
  output logic        give_valid,
  output logic        entry_err,
  output logic        timeout
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {StCollect, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [13:0]     acc_q, acc_d;
  logic [13:0]     intake_q, intake_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic            give_q, give_d;
  logic            err_q, err_d;
  logic            tout_q, tout_d;

  logic [16:0]     acc_mul;
  logic            digit_ok;
  logic            in_range;
  logic            wait_last;

  // The 9999 bound can never trip with MAX_DIGITS=4; it guards wider digit counts.
  assign acc_mul   = 17'(acc_q) * 17'd10 + 17'(digit);
  assign digit_ok  = (digit <= 4'd9) && (cnt_q < CntW'(MAX_DIGITS)) && (acc_mul <= 17'd9999);
  assign in_range  = (acc_q >= 14'(MIN_INTAKE)) && (acc_q <= 14'(MAX_INTAKE));
  // Fires on the edge where wcnt would step onto WAIT_LIMIT-1.
  assign wait_last = (17'(wcnt_q) + 17'd1) >= (17'(WAIT_LIMIT) - 17'd1);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    intake_d = intake_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    give_d   = 1'b0;
    err_d    = 1'b0;
    tout_d   = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (digit_enter) begin
          // Enter wins over a same-cycle digit and is judged on the current accumulator.
          if (cnt_q == '0) begin
            err_d = 1'b1;
          end else if (!in_range) begin
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            intake_d = acc_q;
            give_d   = 1'b1;
            state_d  = StIssue;
          end
        end else if (digit_valid) begin
          if (digit_ok) begin
            acc_d = acc_mul[13:0];
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: begin
        acc_d   = '0;
        cnt_d   = '0;
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (out_valid) begin
          state_d = StCollect;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
          if (wait_last) begin
            tout_d  = 1'b1;
            state_d = StCollect;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StCollect;
      acc_q    <= '0;
      intake_q <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      give_q   <= 1'b0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      intake_q <= intake_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      give_q   <= give_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  assign ready      = (state_q == StCollect);
  assign Intake     = intake_q;
  assign give_valid = give_q;
  assign entry_err  = err_q;
  assign timeout    = tout_q;

endmodule

// File: tb/tb_intake_loader.sv
// Table-driven bench for intake_loader with a give_valid scoreboard and hand-written
// asynchronous-reset sequences.
module tb_intake_loader;

  logic        clk;
  logic        reset;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        digit_enter;
  logic        out_valid;
  logic        ready;
  logic [13:0] Intake;
  logic        give_valid;
  logic        entry_err;
  logic        timeout;

  intake_loader #(
    .MIN_INTAKE(3),
    .MAX_INTAKE(9972),
    .MAX_DIGITS(4),
    .WAIT_LIMIT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_valid(digit_valid),
    .digit      (digit),
    .digit_enter(digit_enter),
    .out_valid  (out_valid),
    .ready      (ready),
    .Intake     (Intake),
    .give_valid (give_valid),
    .entry_err  (entry_err),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  d;
    logic        en;
    logic        ov;
    logic        rdy;
    logic        err;
    logic        gv;
    logic        to;
    logic [13:0] intk;
  } vec_t;

  vec_t        tbl[$];
  logic [13:0] sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dv, input logic [3:0] d, input logic en, input logic ov,
                              input logic rdy, input logic err, input logic gv, input logic to,
                              input logic [13:0] intk);
    vec_t v;
    v.dv = dv; v.d = d; v.en = en; v.ov = ov;
    v.rdy = rdy; v.err = err; v.gv = gv; v.to = to; v.intk = intk;
    return v;
  endfunction

  function automatic vec_t dig(input logic [3:0] d, input logic err, input logic [13:0] intk);
    return mk(1'b1, d, 1'b0, 1'b0, 1'b1, err, 1'b0, 1'b0, intk);
  endfunction

  task automatic step(input vec_t v);
    digit_valid = v.dv;
    digit       = v.d;
    digit_enter = v.en;
    out_valid   = v.ov;
    if (v.gv) sb.push_back(v.intk);
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(v.rdy));
    chk("entry_err", 32'(entry_err), 32'(v.err));
    chk("give_valid", 32'(give_valid), 32'(v.gv));
    chk("timeout", 32'(timeout), 32'(v.to));
    chk("Intake", 32'(Intake), 32'(v.intk));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_Intake"}, 32'(Intake), 32'd0);
    chk({nm, "_give_valid"}, 32'(give_valid), 32'd0);
    chk({nm, "_entry_err"}, 32'(entry_err), 32'd0);
    chk({nm, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // Every give_valid pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (reset === 1'b1 && (give_valid | entry_err | timeout) === 1'b1)
      chk("pulse_onehot", 32'($countones({give_valid, entry_err, timeout})), 32'd1);
    if (reset === 1'b1 && give_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_give", 32'(Intake), 32'h7fff);
      end else begin
        chk("sb_Intake", 32'(Intake), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [13:0] ik;
    reset = 1'b0; digit_valid = 1'b0; digit = '0; digit_enter = 1'b0; out_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;

    ik = 14'd0;
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, ik));           // enter with no digits
    tbl.push_back(dig(2, 0, ik));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, ik));           // 2 < MIN
    tbl.push_back(dig(9, 0, ik)); tbl.push_back(dig(9, 0, ik));
    tbl.push_back(dig(7, 0, ik)); tbl.push_back(dig(3, 0, ik));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, ik));           // 9973 > MAX
    tbl.push_back(dig(1, 0, ik)); tbl.push_back(dig(0, 0, ik));
    tbl.push_back(dig(0, 0, ik)); tbl.push_back(dig(0, 0, ik));
    ik = 14'd1000;
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, ik));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ik));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, ik));
    tbl.push_back(dig(9, 0, ik)); tbl.push_back(dig(9, 0, ik));
    tbl.push_back(dig(7, 0, ik)); tbl.push_back(dig(2, 0, ik));
    ik = 14'd9972;
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, ik));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, ik));           // out_valid in ISSUE ignored
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, ik));
    tbl.push_back(dig(1, 0, ik)); tbl.push_back(dig(2, 0, ik));
    tbl.push_back(dig(3, 0, ik)); tbl.push_back(dig(4, 0, ik));
    tbl.push_back(dig(5, 1, ik));                            // fifth digit rejected
    ik = 14'd1234;
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, ik));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, ik));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, ik));
    tbl.push_back(dig(3, 0, ik));
    tbl.push_back(dig(4'hA, 1, ik));                         // non-decimal digit
    tbl.push_back(dig(5, 0, ik));
    ik = 14'd35;
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, ik));
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, ik));           // digits during ISSUE/WAIT ignored
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, ik));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, ik));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, ik));
    tbl.push_back(dig(1, 0, ik)); tbl.push_back(dig(7, 0, ik));
    ik = 14'd17;
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 1, 0, ik));           // enter beats same-cycle digit
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ik));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, ik));           // watchdog, 8 cycles after give
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, ik));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset during WAIT.
    step(dig(5, 0, ik));
    step(dig(0, 0, ik));
    ik = 14'd50;
    step(mk(0, 0, 1, 0, 0, 0, 1, 0, ik));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, ik));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, ik));
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_wait");
    @(posedge clk);
    #1;
    reset = 1'b1;
    ik = 14'd0;
    // Reset after two digits.
    step(dig(4, 0, ik));
    step(dig(2, 0, ik));
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_entry");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(dig(0, 0, ik)); step(dig(0, 0, ik)); step(dig(5, 0, ik));
    ik = 14'd5;
    step(mk(0, 0, 1, 0, 0, 0, 1, 0, ik));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, ik));
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, ik));
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, ik));

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
